serial_mem_server: RTL and testbench

Bit-serial memory responder on the far side of the CPU's serial instruction and micro-instruction address links. It deserializes an address arriving MSB-first and looks up a locally written word array. It then serializes the word back MSB-first on the CPU's instruction input. One instance serves the instruction stream, configured for PC and instruction widths; a second instance serves the micro-instruction stream, configured for micro-address and micro-instruction widths.

---
 rtl/serial_mem_server.sv | 154 +++++++++++++++
 tb/tb_serial_mem_server.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_mem_server.sv
// serial_mem_server: bit-serial address in, bit-serial data word out.
// A local word array is loaded through a parallel write port. Each request
// shifts in an ADDR_W-bit address MSB-first, looks up one word and shifts it
// back out MSB-first after an optional fixed gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first address bit
// RX_ADDR | shifting in the remaining address bits
// LOOKUP  | one cycle: capture mem[addr] (or zero) into the shift register
// GAP     | RESP_GAP idle cycles before the first data bit
// TX_DATA | shifting the captured word out, DATA_W cycles
module serial_mem_server #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32,
  parameter int RESP_GAP = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  input  logic                     addr_valid,
  input  logic                     addr_bit,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     data_bit,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     abort_err,
  output logic                     overrun
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(ADDR_W + 1);
  localparam int TMR_W  = $clog2(((DATA_W > 16) ? DATA_W : 16) + 1);

  typedef enum logic [2:0] {IDLE, RX_ADDR, LOOKUP, GAP, TX_DATA} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [TMR_W-1:0]    tmr_q, tmr_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic                abort_n, overrun_n;
  logic                data_bit_n, data_valid_n, busy_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [31:0]         addr_ext, wr_ext;
  logic [DATA_W-1:0]   rd_word;

  // Full-width compares so out-of-range addresses never alias onto valid words.
  assign addr_ext = 32'(addr_q);
  assign wr_ext   = 32'(wr_addr);
  assign rd_word  = (addr_ext < 32'(DEPTH)) ? mem[addr_ext[MEM_AW-1:0]] : '0;

  // Storage array: no reset so contents survive a control reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en && (wr_ext < 32'(DEPTH))) mem[wr_ext[MEM_AW-1:0]] <= wr_data;
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) state <= IDLE;
    else            state <= state_n;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    cnt_n     = cnt_q;
    tmr_n     = tmr_q;
    shift_n   = shift_q;
    abort_n   = 1'b0;
    overrun_n = overrun;
    case (state)
      IDLE: begin
        if (addr_valid) begin
          addr_n  = ADDR_W'(addr_bit);
          cnt_n   = CNT_W'(1);
          state_n = (ADDR_W == 1) ? LOOKUP : RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (addr_valid) begin
          addr_n = ADDR_W'({addr_q, addr_bit});
          cnt_n  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) state_n = LOOKUP;
        end else begin
          abort_n = 1'b1;
          addr_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      LOOKUP: begin
        shift_n = rd_word;
        cnt_n   = '0;
        if (RESP_GAP > 0) begin
          state_n = GAP;
          tmr_n   = TMR_W'(RESP_GAP - 1);
        end else begin
          state_n = TX_DATA;
          tmr_n   = TMR_W'(DATA_W - 1);
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_n = TX_DATA;
          tmr_n   = TMR_W'(DATA_W - 1);
        end else begin
          tmr_n = tmr_q - TMR_W'(1);
        end
      end
      TX_DATA: begin
        shift_n = shift_q << 1;
        if (tmr_q == '0) state_n = IDLE;
        else             tmr_n   = tmr_q - TMR_W'(1);
      end
      default: state_n = IDLE;
    endcase
    // Address bits arriving while a response is pending are dropped but flagged.
    if (addr_valid && (state == LOOKUP || state == GAP || state == TX_DATA))
      overrun_n = 1'b1;
    data_valid_n = (state_n == TX_DATA);
    data_bit_n   = data_valid_n & shift_n[DATA_W-1];
    busy_n       = (state_n != IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      shift_q    <= '0;
      data_bit   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      abort_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      addr_q     <= addr_n;
      cnt_q      <= cnt_n;
      tmr_q      <= tmr_n;
      shift_q    <= shift_n;
      data_bit   <= data_bit_n;
      data_valid <= data_valid_n;
      busy       <= busy_n;
      abort_err  <= abort_n;
      overrun    <= overrun_n;
    end
  end

endmodule

// File: tb/tb_serial_mem_server.sv
// Directed bench for serial_mem_server: one instance with default widths,
// one with a 9-bit address and a 2-cycle response gap.
module tb_serial_mem_server;

  logic clk = 1'b0;
  logic rst_n;
  logic av0, ab0, we0, av1, ab1, we1;
  logic [4:0] wa0, wa1;
  logic [15:0] wd0, wd1;
  logic db0, dv0, bz0, ae0, ov0;
  logic db1, dv1, bz1, ae1, ov1;

  int total = 0;
  int bad = 0;

  // per-request observations
  logic [15:0] r_word;
  int r_first, r_ndv, r_busy_low, r_nabort, r_abort_cyc, r_dbz;
  logic r_busy1;
  logic [4:0] r_rst_outs;

  always #5 clk = ~clk;

  serial_mem_server #(.ADDR_W(8), .DATA_W(16), .DEPTH(32), .RESP_GAP(0)) u0 (
    .sys_clk(clk), .sys_reset(rst_n), .addr_valid(av0), .addr_bit(ab0),
    .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
    .data_bit(db0), .data_valid(dv0), .busy(bz0), .abort_err(ae0), .overrun(ov0));

  serial_mem_server #(.ADDR_W(9), .DATA_W(16), .DEPTH(32), .RESP_GAP(2)) u1 (
    .sys_clk(clk), .sys_reset(rst_n), .addr_valid(av1), .addr_bit(ab1),
    .wr_en(we1), .wr_addr(wa1), .wr_data(wd1),
    .data_bit(db1), .data_valid(dv1), .busy(bz1), .abort_err(ae1), .overrun(ov1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    if (sel == 0) begin we0 = 1'b1; wa0 = a; wd0 = d; end
    else          begin we1 = 1'b1; wa1 = a; wd1 = d; end
    @(negedge clk);
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle c = inputs applied during c; outputs observed at the same negedge
  // are those registered at the edge that opened cycle c.
  task automatic run_req(input int sel, input logic [8:0] a, input int aw,
                         input int abort_after, input int pulse_at,
                         input int wr_at, input logic [15:0] wr_word, input int rst_at);
    logic o_db, o_dv, o_bz, o_ae, o_ov, v, b;
    r_word = '0; r_first = -1; r_ndv = 0; r_busy_low = -1; r_busy1 = 1'b0;
    r_nabort = 0; r_abort_cyc = -1; r_dbz = 0; r_rst_outs = '1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (sel == 0) {o_db, o_dv, o_bz, o_ae, o_ov} = {db0, dv0, bz0, ae0, ov0};
      else          {o_db, o_dv, o_bz, o_ae, o_ov} = {db1, dv1, bz1, ae1, ov1};
      if (c >= 1) begin
        if (o_dv) begin
          if (r_first < 0) r_first = c;
          r_word = {r_word[14:0], o_db};
          r_ndv++;
        end else if (o_db) r_dbz++;
        if (c == 1) r_busy1 = o_bz;
        if (!o_bz && r_busy_low < 0) r_busy_low = c;
        if (o_ae) begin
          r_nabort++;
          if (r_abort_cyc < 0) r_abort_cyc = c;
        end
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        r_rst_outs = {o_db, o_dv, o_bz, o_ae, o_ov};
        rst_n = 1'b1;
      end
      if (c == rst_at) rst_n = 1'b0;
      v = ((c < aw) && (abort_after < 0 || c < abort_after)) || (c == pulse_at);
      b = (c < aw) ? a[aw-1-c] : 1'b0;
      if (sel == 0) begin
        av0 = v; ab0 = b; we0 = (c == wr_at); wa0 = a[4:0]; wd0 = wr_word;
      end else begin
        av1 = v; ab1 = b; we1 = (c == wr_at); wa1 = a[4:0]; wd1 = wr_word;
      end
    end
    av0 = 1'b0; av1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    av0 = 0; ab0 = 0; we0 = 0; wa0 = '0; wd0 = '0;
    av1 = 0; ab1 = 0; we1 = 0; wa1 = '0; wd1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs_u0", {db0, dv0, bz0, ae0, ov0}, 5'b0);
    chk("reset_outs_u1", {db1, dv1, bz1, ae1, ov1}, 5'b0);
    rst_n = 1'b1;

    wr(0, 5'd5, 16'hA55A);

    // basic read of address 5
    run_req(0, 9'h005, 8, -1, -1, -1, 16'h0, -1);
    chk("a_first_dv", r_first, 9);
    chk("a_ndv", r_ndv, 16);
    chk("a_word", r_word, 16'hA55A);
    chk("a_busy_c1", r_busy1, 1'b1);
    chk("a_busy_low", r_busy_low, 25);
    chk("a_abort", r_nabort, 0);
    chk("a_dbit_idle", r_dbz, 0);

    // address beyond depth reads zero
    run_req(0, 9'h040, 8, -1, -1, -1, 16'h0, -1);
    chk("b_ndv", r_ndv, 16);
    chk("b_word", r_word, 16'h0000);
    chk("b_abort", r_nabort, 0);
    chk("b_overrun", ov0, 1'b0);

    // frame cut after 3 bits
    run_req(0, 9'h005, 8, 3, -1, -1, 16'h0, -1);
    chk("c_nabort", r_nabort, 1);
    chk("c_abort_cyc", r_abort_cyc, 4);
    chk("c_ndv", r_ndv, 0);
    chk("c_busy_low", r_busy_low, 4);
    run_req(0, 9'h005, 8, -1, -1, -1, 16'h0, -1);
    chk("c_next_word", r_word, 16'hA55A);

    // addr_valid pulse during TX_DATA
    run_req(0, 9'h005, 8, -1, 12, -1, 16'h0, -1);
    chk("d_word", r_word, 16'hA55A);
    chk("d_ndv", r_ndv, 16);
    chk("d_overrun", ov0, 1'b1);
    repeat (100) @(negedge clk);
    chk("d_overrun_sticky", ov0, 1'b1);
    pulse_reset();
    chk("d_overrun_clr", ov0, 1'b0);

    // write during LOOKUP returns the old word
    run_req(0, 9'h005, 8, -1, -1, 8, 16'h1234, -1);
    chk("e_old_word", r_word, 16'hA55A);
    run_req(0, 9'h005, 8, -1, -1, -1, 16'h0, -1);
    chk("e_new_word", r_word, 16'h1234);

    // reset at data bit 7 (cycle 16)
    run_req(0, 9'h005, 8, -1, -1, -1, 16'h0, 16);
    chk("f_rst_outs", r_rst_outs, 5'b0);
    run_req(0, 9'h005, 8, -1, -1, -1, 16'h0, -1);
    chk("f_word", r_word, 16'h1234);
    chk("f_first_dv", r_first, 9);

    // 9-bit address, 2-cycle gap
    wr(1, 5'd5, 16'h1234);
    run_req(1, 9'h005, 9, -1, -1, -1, 16'h0, -1);
    chk("g_first_dv", r_first, 12);
    chk("g_word", r_word, 16'h1234);
    chk("g_busy_low", r_busy_low, 28);
    run_req(1, 9'h105, 9, -1, -1, -1, 16'h0, -1);
    chk("g_oob_word", r_word, 16'h0000);
    chk("g_oob_ndv", r_ndv, 16);
    run_req(1, 9'h005, 9, -1, -1, -1, 16'h0, 19);
    chk("g_rst_outs", r_rst_outs, 5'b0);
    run_req(1, 9'h005, 9, -1, -1, -1, 16'h0, -1);
    chk("g_after_rst_word", r_word, 16'h1234);
    chk("g_after_rst_first", r_first, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
